// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, addresses a combinational instruction memory and
// hands {pc, instr} to decode over valid/ready, with redirect, halt and counting.
module instr_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    localparam int unsigned XLEN = 32;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic [XLEN-1:0]   out_instr_q, out_instr_d;
    logic              halted_q, halted_d;
    logic              misalign_q, misalign_d;
    logic [XLEN-1:0]   count_q, count_d;
    logic              accept_c;
    logic              load_c;

    // State register; synchronous reset discards any stall or halt in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_RUN;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= '0;
            halted_q    <= 1'b0;
            misalign_q  <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            halted_q    <= halted_d;
            misalign_q  <= misalign_d;
            count_q     <= count_d;
        end
    end

    // Next-state: redirect flushes, otherwise load when the output slot frees up.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        halted_d    = halted_q;
        misalign_d  = 1'b0;
        count_d     = count_q;

        accept_c = out_valid_q & out_ready;
        load_c   = (state_q == S_RUN) & (~out_valid_q | out_ready) & ~redirect_valid;

        // An accept coinciding with a redirect was still delivered, so it counts.
        if (accept_c) begin
            count_d = count_q + XLEN'(1);
        end

        if (redirect_valid) begin
            pc_d        = {redirect_pc[XLEN-1:2], 2'b00};
            out_valid_d = 1'b0;
            state_d     = S_RUN;
            halted_d    = 1'b0;
            misalign_d  = |redirect_pc[1:0];
        end else if (load_c) begin
            out_instr_d = imem_data;
            out_pc_d    = pc_q;
            out_valid_d = 1'b1;
            pc_d        = pc_q + XLEN'(4);
            if (imem_data == HALT_INSTR) begin
                state_d  = S_HALT;
                halted_d = 1'b1;
            end
        end else if (accept_c) begin
            out_valid_d = 1'b0;
        end
    end

    assign imem_addr    = pc_q;
    assign out_valid    = out_valid_q;
    assign out_pc       = out_pc_q;
    assign out_instr    = out_instr_q;
    assign halted       = halted_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: a transaction-level model predicts
// each fetched {pc, instr}; a negedge monitor compares what the DUT presents.
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] HALT_INSTR = 32'h0000_0073;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    logic        clk;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        halted;
    logic        misalign_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:63];
    item_t       exp_q [$];
    logic [31:0] m_pc;
    logic        m_run;
    logic        m_halted;
    logic        m_mis;
    logic [31:0] m_count;
    logic        mon_en;
    int          n_cmp;
    int          n_err;

    instr_fetch #(.RESET_PC(RESET_PC), .HALT_INSTR(HALT_INSTR)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .halted         (halted),
        .misalign_err   (misalign_err),
        .fetch_count    (fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small memory image at low addresses; elsewhere a never-halt address pattern.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'd256) return mem[a[7:2]];
        return {~a[31:2], 2'b01};
    endfunction

    always_comb imem_data = mem_word(imem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: per-cycle state checks plus pop/compare of the presented item.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("imem_addr", imem_addr, m_pc);
            chk("halted", 32'(halted), 32'(m_halted));
            chk("misalign_err", 32'(misalign_err), 32'(m_mis));
            chk("fetch_count", fetch_count, m_count);
            chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("out_pc", out_pc, exp_q[0].pc);
                chk("out_instr", out_instr, exp_q[0].instr);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    // One clock of stimulus, then advance the reference model across that edge.
    task automatic cycle(input logic r, input logic rv, input logic [31:0] rp, input logic rdy);
        logic  pre_valid;
        logic  acc;
        logic [31:0] w;
        rst            = r;
        redirect_valid = rv;
        redirect_pc    = rp;
        out_ready      = rdy;
        pre_valid      = (exp_q.size() != 0);
        acc            = pre_valid && rdy;
        @(posedge clk);
        #1;
        if (r) begin
            exp_q.delete();
            m_pc     = RESET_PC;
            m_run    = 1'b1;
            m_halted = 1'b0;
            m_mis    = 1'b0;
            m_count  = 32'd0;
        end else begin
            if (acc) m_count = m_count + 32'd1;
            if (rv) begin
                exp_q.delete();
                m_pc     = rp & 32'hFFFF_FFFC;
                m_mis    = (rp[1:0] != 2'b00);
                m_run    = 1'b1;
                m_halted = 1'b0;
            end else begin
                m_mis = 1'b0;
                if (m_run && (!pre_valid || rdy)) begin
                    w = mem_word(m_pc);
                    exp_q.push_back('{pc: m_pc, instr: w});
                    if (w == HALT_INSTR) begin
                        m_run    = 1'b0;
                        m_halted = 1'b1;
                    end
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    initial begin
        logic [31:0] tgt;
        n_cmp = 0;
        n_err = 0;
        mon_en = 1'b0;
        m_pc = RESET_PC; m_run = 1'b1; m_halted = 1'b0; m_mis = 1'b0; m_count = 32'd0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_1000 + 32'(i);
        mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;

        // Reset, then stream with a 3-cycle stall at out_pc=4.
        cycle(1'b1, 1'b0, 32'd0, 1'b1);
        mon_en = 1'b1;
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_imem_addr", imem_addr, RESET_PC);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("first_pc", out_pc, 32'h0);
        chk("first_instr", out_instr, 32'h11);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b0);
        chk("stall_pc", out_pc, 32'h4);
        chk("stall_instr", out_instr, 32'h22);
        chk("stall_addr", imem_addr, 32'h8);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("after_stall_pc", out_pc, 32'h8);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("count_after_4", fetch_count, 32'd4);

        // Redirect flush while stalled.
        cycle(1'b0, 1'b1, 32'h20, 1'b0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_addr", imem_addr, 32'h20);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        chk("target_pc", out_pc, 32'h20);
        chk("target_instr", out_instr, 32'h1008);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Misaligned redirect.
        cycle(1'b0, 1'b1, 32'h1E, 1'b1);
        chk("mis_pulse", 32'(misalign_err), 32'd1);
        chk("mis_addr", imem_addr, 32'h1C);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("mis_clear", 32'(misalign_err), 32'd0);

        // Halt at word 2, then resume via redirect.
        mem[2] = HALT_INSTR;
        cycle(1'b0, 1'b1, 32'h0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("halt_pc", out_pc, 32'h8);
        chk("halt_instr", out_instr, HALT_INSTR);
        chk("halted_set", 32'(halted), 32'd1);
        cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("halt_drained", 32'(out_valid), 32'd0);
        tgt = fetch_count;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);
        chk("halt_count_frozen", fetch_count, tgt);
        cycle(1'b0, 1'b1, 32'h0, 1'b1);
        chk("resume_halted", 32'(halted), 32'd0);
        mem[2] = 32'h33;
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'd0, 1'b1);

        // Reset mid-stall, then PC wrap.
        cycle(1'b0, 1'b1, 32'h10, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        cycle(1'b1, 1'b0, 32'd0, 1'b0);
        chk("rst_stall_valid", 32'(out_valid), 32'd0);
        chk("rst_stall_count", fetch_count, 32'd0);
        chk("rst_stall_addr", imem_addr, RESET_PC);
        cycle(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
        cycle(1'b0, 1'b0, 32'd0, 1'b0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_out_pc", out_pc, 32'hFFFF_FFFC);

        // Randomized traffic with halts sprinkled in the image.
        mem[21] = HALT_INSTR;
        mem[45] = HALT_INSTR;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 7) == 0)
                tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else
                tgt = 32'($urandom_range(0, 255));
            cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                  tgt,
                  ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time bound so the bench can never hang.
    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time bound, got no finish expected finish");
        $fatal(1);
    end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the combinational instruction memory. Owns the program counter and drives the word-aligned byte address into the memory.
- Captures the returned instruction word into an output register and hands {pc, instr} to decode over a valid/ready handshake.
- Supports branch/jump redirect with flush, back-pressure from decode, halt detection, and a delivered-instruction counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be 4-byte aligned.
- HALT_INSTR, 32'h0000_0073, instruction word that stops fetching once captured.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals the pc register.
- imem_data  input  32  instruction word returned combinationally for imem_addr, same cycle.
- redirect_valid  input  1  load a new PC this cycle (branch/jump taken).
- redirect_pc  input  32  target byte address.
- out_valid  output  1  out_pc/out_instr hold a valid fetched instruction.
- out_ready  input  1  decode accepts the instruction this cycle.
- out_pc  output  32  address of out_instr.
- out_instr  output  32  fetched instruction word.
- halted  output  1  fetch stopped on HALT_INSTR.
- misalign_err  output  1  one-cycle pulse: redirect_pc[1:0] was nonzero.
- fetch_count  output  32  number of instructions accepted by decode.

Behaviour:
- Reset (rst=1 at an edge), wins over every other input:
  - pc <= RESET_PC
  - out_valid, halted, misalign_err <= 0
  - out_pc, out_instr, fetch_count <= 0
  - state <= RUN
  - A reset mid-stall or mid-halt discards everything.
- imem_addr = pc, combinational from the register. The memory returns the word for that address in the same cycle; there are no wait states.
- Accept = out_valid & out_ready. fetch_count += 1 on each accept and wraps 2^32-1 -> 0.
- Load condition: state==RUN & (~out_valid | out_ready) & ~redirect_valid. On load:
  - out_instr <= imem_data; out_pc <= pc; out_valid <= 1; pc <= pc + 4.
  - pc wraps modulo 2^32 (32'hFFFF_FFFC -> 0).
  - Accept and load in the same cycle give a continuous stream of one instruction per cycle.
- Stall: out_valid=1 & out_ready=0. out_pc, out_instr and pc hold stable; no load occurs.
- State machine, two states:
  - RUN: normal fetching.
  - HALT: entered on the edge where a load captures imem_data==HALT_INSTR. The halt instruction itself is presented (out_valid=1) and is still delivered to decode. halted=1 from the next cycle. pc still advances by 4 on that load. In HALT, no further loads occur; out_valid clears after the halt instruction is accepted.
  - HALT -> RUN only on redirect_valid or rst.
- Redirect, highest priority after reset, any state:
  - pc <= {redirect_pc[31:2], 2'b00}; out_valid <= 0 (flush, even if decode is asserting out_ready); state <= RUN; halted <= 0.
  - A simultaneous accept is still counted in fetch_count.
  - misalign_err <= (redirect_pc[1:0] != 0) for exactly one cycle; otherwise 0.
  - First instruction from the target appears with out_valid=1 one cycle after the redirect edge.
- Latency: instruction at address A is valid on out_* one cycle after pc==A.
- Steady-state throughput: 1 instruction/cycle while out_ready=1.

Test Plan:
- Reset then stream: memory words 0..3 = 0x11,0x22,0x33,0x44, out_ready=1 -> cycle after reset out_pc=0/out_instr=0x11, then pc 4/8/12 with 0x22/0x33/0x44 on consecutive cycles; fetch_count=4 after 4 accepts.
- Back-pressure: out_ready=0 for 3 cycles while out_pc=4 -> out_pc=4, out_instr=0x22, imem_addr=8 held stable; on out_ready=1, next cycle out_pc=8, no skipped or duplicated word.
- Redirect flush: redirect_valid=1, redirect_pc=0x20 while out_valid=1, out_ready=0 -> next cycle out_valid=0, imem_addr=0x20; following cycle out_pc=0x20 with word 8; misalign_err stays 0.
- Misaligned redirect: redirect_pc=0x1E -> pc=0x1C, misalign_err=1 for exactly one cycle.
- Halt: word 2 = 0x00000073 -> out_instr=0x73 delivered at out_pc=8, halted=1 next cycle, out_valid=0 after accept, fetch_count frozen; a later redirect to 0x0 resumes with halted=0.
- Reset mid-stall: rst=1 while stalled at pc=0x10 -> next cycle out_valid=0, fetch_count=0, imem_addr=RESET_PC; PC wrap check: redirect to 0xFFFFFFFC, then one load -> pc=0x0.
